// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO registers.
// One result bit is produced per cycle. A single 2*WIDTH shift register holds
// the multiply accumulator or the divide remainder/quotient pair. A final FIX
// cycle applies the sign corrections before anything reaches hi/lo.

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 b_zero;
    logic [WIDTH-1:0]     orig_a;
    logic [WIDTH-1:0]     operand_b;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;

    // Operand magnitudes and sign information for the accept edge
    logic                 op_signed;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    // One-step datapath values for multiply and divide
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;

    // Sign-corrected results presented at the FIX edge
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Signed ops work on magnitudes; the most-negative value maps onto itself,
    // which reads correctly as 2^(WIDTH-1) once treated as unsigned.
    always_comb begin
        op_signed = ~md_op[2] & ~md_op[0];
        mag_a     = (op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b     = (op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // Single iteration of shift-add multiply and restoring divide.
    // Multiply: upper half accumulates, lower half holds the multiplier and
    // shifts out LSB-first. Divide: upper half is the remainder, lower half
    // shifts dividend bits out MSB-first and quotient bits in at the bottom.
    // Because remainder < divisor, the trial difference's top bit is exactly
    // the borrow, so it doubles as the "remainder >= divisor" test.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_b};
        div_ge    = ~div_diff[WIDTH];
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ge};
    end

    // Final sign fix-up of product, quotient and remainder
    always_comb begin
        prod_fix = neg_q ? (~acc + 1'b1) : acc;
        quot_fix = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered outputs; hi/lo only change at MTHI/MTLO
    // accept or at the FIX edge so intermediate iterations are never visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            b_zero      <= 1'b0;
            orig_a      <= '0;
            operand_b   <= '0;
            acc         <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            3'b100: begin
                                hi          <= a;
                                done        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                            3'b101: begin
                                lo          <= a;
                                done        <= 1'b1;
                                div_by_zero <= 1'b0;
                            end
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div    <= md_op[1];
                                neg_q     <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r     <= op_signed & a[WIDTH-1];
                                b_zero    <= (b == '0);
                                orig_a    <= a;
                                operand_b <= mag_b;
                                acc       <= {{WIDTH{1'b0}}, mag_a};
                                count     <= CW'(WIDTH);
                                busy      <= 1'b1;
                                state     <= RUN;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        if (b_zero) begin
                            hi          <= orig_a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi          <= rem_fix;
                            lo          <= quot_fix;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        hi          <= prod_fix[2*WIDTH-1:WIDTH];
                        lo          <= prod_fix[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// plain-arithmetic reference model (64-bit products, SV / and % for divides).

module tb_muldiv_unit;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [2:0]  md_op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic        div_by_zero8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int checks;
    int errors;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .md_op       (md_op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start8),
        .md_op       (md_op8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .div_by_zero (div_by_zero8),
        .hi          (hi8),
        .lo          (lo8)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: architectural effect of one operation on HI/LO
    task automatic model_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] p;
        sa = longint'($signed(x));
        sb = longint'($signed(y));
        case (op)
            3'b000: begin
                p = 64'(sa * sb);
                {exp_hi, exp_lo} = p;
                exp_dz = 1'b0;
            end
            3'b001: begin
                p = 64'(x) * 64'(y);
                {exp_hi, exp_lo} = p;
                exp_dz = 1'b0;
            end
            3'b010, 3'b011: begin
                if (y == 32'd0) begin
                    exp_hi = x;
                    exp_lo = 32'hFFFF_FFFF;
                    exp_dz = 1'b1;
                end else if (op == 3'b010) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p  = 64'(sq);
                    exp_lo = p[31:0];
                    p  = 64'(sr);
                    exp_hi = p[31:0];
                    exp_dz = 1'b0;
                end else begin
                    exp_lo = x / y;
                    exp_hi = x % y;
                    exp_dz = 1'b0;
                end
            end
            3'b100: begin
                exp_hi = x;
                exp_dz = 1'b0;
            end
            3'b101: begin
                exp_lo = x;
                exp_dz = 1'b0;
            end
            default: begin
                exp_dz = exp_dz;
            end
        endcase
    endtask

    // Issue one op on the 32-bit unit and check latency, handshake and results
    task automatic apply_stimulus(input string tag, input logic [2:0] op,
                                  input logic [31:0] x, input logic [31:0] y);
        int          cycles;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        prev_hi = hi;
        prev_lo = lo;
        @(negedge clock);
        md_op = op;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        model_op(op, x, y);
        if (op >= 3'b100) begin
            check_output({tag, "_busy"}, 64'(busy), 64'(0));
            check_output({tag, "_done"}, 64'(done), 64'(1));
        end else begin
            check_output({tag, "_busy"}, 64'(busy), 64'(1));
            cycles = 0;
            while (done !== 1'b1 && cycles < 100) begin
                @(posedge clock);
                #1;
                cycles++;
                if (cycles == 16) begin
                    check_output({tag, "_mid_hilo"}, {hi, lo}, {prev_hi, prev_lo});
                end
            end
            check_output({tag, "_latency"}, 64'(cycles), 64'(33));
            check_output({tag, "_busy_end"}, 64'(busy), 64'(0));
        end
        check_output({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check_output({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check_output({tag, "_dz"}, 64'(div_by_zero), 64'(exp_dz));
        @(posedge clock);
        #1;
        check_output({tag, "_done_pulse"}, 64'(done), 64'(0));
    endtask

    // Issue one op on the 8-bit unit and check latency and results
    task automatic apply_stimulus8(input string tag, input logic [2:0] op,
                                   input logic [7:0] x, input logic [7:0] y,
                                   input logic [7:0] want_hi, input logic [7:0] want_lo);
        int cycles;
        @(negedge clock);
        md_op8 = op;
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        @(posedge clock);
        #1;
        start8 = 1'b0;
        cycles = 0;
        while (done8 !== 1'b1 && cycles < 100) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        check_output({tag, "_latency"}, 64'(cycles), 64'(9));
        check_output({tag, "_hi"}, 64'(hi8), 64'(want_hi));
        check_output({tag, "_lo"}, 64'(lo8), 64'(want_lo));
    endtask

    // Main directed + randomized sequence
    initial begin
        int          cycles;
        int          n_done;
        logic [2:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [7:0]  x8;
        logic [7:0]  y8;
        logic [15:0] p16;

        checks  = 0;
        errors  = 0;
        exp_hi  = '0;
        exp_lo  = '0;
        exp_dz  = 1'b0;
        reset_n = 1'b0;
        start   = 1'b0;
        md_op   = 3'b000;
        a       = '0;
        b       = '0;
        start8  = 1'b0;
        md_op8  = 3'b000;
        a8      = '0;
        b8      = '0;

        #12;
        check_output("reset_busy", 64'(busy), 64'(0));
        check_output("reset_done", 64'(done), 64'(0));
        check_output("reset_hilo", {hi, lo}, 64'(0));
        check_output("reset_dz", 64'(div_by_zero), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] directed multiply/divide");
        apply_stimulus("mult", 3'b000, 32'hFFFF_FFFE, 32'd3);
        check_output("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        apply_stimulus("multu", 3'b001, 32'hFFFF_FFFE, 32'd3);
        check_output("multu_const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
        apply_stimulus("div", 3'b010, 32'hFFFF_FFF9, 32'd2);
        check_output("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        apply_stimulus("divu", 3'b011, 32'd7, 32'd2);
        check_output("divu_const", {hi, lo}, 64'h0000_0001_0000_0003);
        apply_stimulus("divu_zero", 3'b011, 32'h0000_1234, 32'd0);
        check_output("divu_zero_const", {hi, lo, 31'd0, div_by_zero},
                     {64'h0000_1234_FFFF_FFFF, 32'd1});
        apply_stimulus("div_minneg", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        check_output("div_minneg_const", {hi, lo}, 64'h0000_0000_8000_0000);
        apply_stimulus("mtlo", 3'b101, 32'hDEAD_BEEF, 32'd0);
        check_output("mtlo_const", 64'(lo), 64'hDEAD_BEEF);
        apply_stimulus("mthi", 3'b100, 32'h1357_9BDF, 32'd0);

        $display("[TB] reserved op ignored");
        @(negedge clock);
        md_op = 3'b110;
        a     = 32'h5555_5555;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_output("reserved_busy_done", {62'd0, busy, done}, 64'd0);
        check_output("reserved_hilo", {hi, lo}, {exp_hi, exp_lo});

        $display("[TB] start held through a MULT, new op on done cycle");
        @(negedge clock);
        md_op = 3'b000;
        a     = 32'h0001_0003;
        b     = 32'hFFFF_0005;
        start = 1'b1;
        @(posedge clock);
        #1;
        model_op(3'b000, 32'h0001_0003, 32'hFFFF_0005);
        cycles = 0;
        n_done = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clock);
            #1;
            cycles++;
            if (busy !== 1'b1 && done !== 1'b1) n_done++;
        end
        check_output("hold_latency", 64'(cycles), 64'(33));
        check_output("hold_busy_gap", 64'(n_done), 64'(0));
        check_output("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
        md_op = 3'b101;
        a     = 32'hCAFE_F00D;
        @(posedge clock);
        #1;
        start = 1'b0;
        model_op(3'b101, 32'hCAFE_F00D, 32'd0);
        check_output("hold_mtlo_done", {62'd0, busy, done}, 64'd1);
        check_output("hold_mtlo_hilo", {hi, lo}, {exp_hi, exp_lo});

        $display("[TB] reset mid-divide");
        @(negedge clock);
        md_op = 3'b010;
        a     = 32'hFFFF_FFF9;
        b     = 32'd2;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("midrst_busy_done", {62'd0, busy, done}, 64'd0);
        check_output("midrst_hilo", {hi, lo}, 64'd0);
        check_output("midrst_dz", 64'(div_by_zero), 64'(0));
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        check_output("midrst_no_done", 64'(n_done), 64'(0));

        $display("[TB] randomized operations");
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 5));
            rx  = $urandom;
            ry  = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 15));
                2: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                default: ry = ry;
            endcase
            apply_stimulus("rand", rop, rx, ry);
        end

        $display("[TB] WIDTH=8 instance");
        apply_stimulus8("w8_multu", 3'b001, 8'hFF, 8'hFF, 8'hFE, 8'h01);
        for (int i = 0; i < 6; i++) begin
            x8 = 8'($urandom);
            y8 = 8'($urandom_range(1, 255));
            if (i % 2 == 0) begin
                p16 = 16'(x8) * 16'(y8);
                apply_stimulus8("w8_rand_multu", 3'b001, x8, y8, p16[15:8], p16[7:0]);
            end else begin
                apply_stimulus8("w8_rand_divu", 3'b011, x8, y8, x8 % y8, x8 / y8);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
